// File: rtl/cg_pkg.sv
// Shared types and range limits for the clock-gate enable controller.
// The statistics counters are built only when CG_STATS_EN is defined.
package cg_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        HOLD = 2'd3
    } cg_state_e;

    localparam int WAKE_CYC_MAX = 15;
    localparam int HOLD_CYC_MAX = 255;

    localparam int WAKE_CNT_W = $clog2(WAKE_CYC_MAX + 1);
    localparam int HOLD_CNT_W = $clog2(HOLD_CYC_MAX + 1);

endpackage

// File: rtl/cg_group_fsm.sv
// One gated register group: wake/hold FSM, registered GATE/ack outputs and,
// when CG_STATS_EN is defined, a saturating count of cycles spent gated off.
module cg_group_fsm
    import cg_pkg::*;
#(
    parameter int WAKE_CYC = 1,
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             stats_clr_i,
    output logic             gate_en_o,
    output logic             ack_o,
    output logic [CNT_W-1:0] gated_cnt_o
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYC);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYC);

    cg_state_e             state_q, state_d;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                  gate_en_q, gate_en_d;
    logic                  ack_q, ack_d;

    // Counters are only meaningful in their own state and are reloaded on
    // entry, so a decrement from zero can never occur.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        hold_cnt_d = hold_cnt_q;
        gate_en_d  = (state_q != OFF);
        ack_d      = (state_q == ON);

        unique case (state_q)
            OFF: begin
                if (req_i) begin
                    if (WAKE_CYC == 0) begin
                        state_d = ON;
                    end else begin
                        state_d    = WAKE;
                        wake_cnt_d = WAKE_LOAD;
                    end
                end
            end
            WAKE: begin
                if (req_i) begin
                    wake_cnt_d = wake_cnt_q - WAKE_CNT_W'(1);
                    if (wake_cnt_q == WAKE_CNT_W'(1)) begin
                        state_d = ON;
                    end
                end else if (HOLD_CYC == 0) begin
                    state_d = OFF;
                end else begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ON: begin
                if (!req_i) begin
                    if (HOLD_CYC == 0) begin
                        state_d = OFF;
                    end else begin
                        state_d    = HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                // The clock never stopped, so a returning request skips WAKE.
                if (req_i) begin
                    state_d = ON;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_CNT_W'(1);
                    if (hold_cnt_q == HOLD_CNT_W'(1)) begin
                        state_d = OFF;
                    end
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OFF;
            wake_cnt_q <= '0;
            hold_cnt_q <= '0;
            gate_en_q  <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            gate_en_q  <= gate_en_d;
            ack_q      <= ack_d;
        end
    end

    assign gate_en_o = gate_en_q;
    assign ack_o     = ack_q;

`ifdef CG_STATS_EN
    logic [CNT_W-1:0] stat_cnt_q, stat_cnt_d;

    always_comb begin
        stat_cnt_d = stat_cnt_q;
        if (stats_clr_i) begin
            stat_cnt_d = '0;
        end else if ((state_q == OFF) && (stat_cnt_q != '1)) begin
            stat_cnt_d = stat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt_q <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign gated_cnt_o = stat_cnt_q;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr_i;
    assign gated_cnt_o      = '0;
`endif

endmodule

// File: rtl/cg_enable_ctrl.sv
// Per-group clock-gate enable controller feeding the ICG GATE pins.
// Define CG_STATS_EN to build the per-group gated-cycle statistics counters.
module cg_enable_ctrl
    import cg_pkg::*;
#(
    parameter int NGRP     = 2,
    parameter int WAKE_CYC = 1,
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NGRP-1:0]       req,
    input  logic                  force_on,
    input  logic                  stats_clr,
    output logic [NGRP-1:0]       gate_en,
    output logic [NGRP-1:0]       ack,
    output logic [NGRP*CNT_W-1:0] gated_cnt
);

    logic [NGRP-1:0] gate_en_raw;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        cg_group_fsm #(
            .WAKE_CYC (WAKE_CYC),
            .HOLD_CYC (HOLD_CYC),
            .CNT_W    (CNT_W)
        ) u_fsm (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_i       (req[g]),
            .stats_clr_i (stats_clr),
            .gate_en_o   (gate_en_raw[g]),
            .ack_o       (ack[g]),
            .gated_cnt_o (gated_cnt[g*CNT_W +: CNT_W])
        );
    end

    // Scan override acts only on the GATE pins; group state and ack are untouched.
    assign gate_en = gate_en_raw | {NGRP{force_on}};

endmodule

// File: tb/tb_cg_enable_ctrl.sv
// Self-checking bench for cg_enable_ctrl with a behavioural per-group model.
// Statistics expectations follow CG_STATS_EN; CNT_W is reduced so saturation is reachable.
module tb_cg_enable_ctrl;

    localparam int NGRP     = 2;
    localparam int WAKE_CYC = 1;
    localparam int HOLD_CYC = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NGRP-1:0]       req;
    logic                  force_on;
    logic                  stats_clr;
    logic [NGRP-1:0]       gate_en;
    logic [NGRP-1:0]       ack;
    logic [NGRP*CNT_W-1:0] gated_cnt;

    int checks   = 0;
    int failures = 0;

    // Model: clock running / clock stable-and-acked / still waking, plus a countdown.
    bit mRunning [NGRP];
    bit mReady   [NGRP];
    bit mWaking  [NGRP];
    int mLeft    [NGRP];
    int mCnt     [NGRP];
    bit expGate  [NGRP];
    bit expAck   [NGRP];

    cg_enable_ctrl #(
        .NGRP     (NGRP),
        .WAKE_CYC (WAKE_CYC),
        .HOLD_CYC (HOLD_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .force_on  (force_on),
        .stats_clr (stats_clr),
        .gate_en   (gate_en),
        .ack       (ack),
        .gated_cnt (gated_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NGRP-1:0] reqV, input logic forceV, input logic clrV);
        req       = reqV;
        force_on  = forceV;
        stats_clr = clrV;
    endtask

    task automatic modelReset();
        for (int g = 0; g < NGRP; g++) begin
            mRunning[g] = 0;
            mReady[g]   = 0;
            mWaking[g]  = 0;
            mLeft[g]    = 0;
            mCnt[g]     = 0;
            expGate[g]  = 0;
            expAck[g]   = 0;
        end
    endtask

    // The outputs seen after an edge reflect where the group was before that edge.
    task automatic modelEdge();
        for (int g = 0; g < NGRP; g++) begin
            expGate[g] = mRunning[g];
            expAck[g]  = mReady[g];
            if (stats_clr)
                mCnt[g] = 0;
            else if (!mRunning[g] && mCnt[g] < CNT_MAX)
                mCnt[g] = mCnt[g] + 1;

            if (!mRunning[g]) begin
                if (req[g]) begin
                    mRunning[g] = 1;
                    if (WAKE_CYC == 0) mReady[g] = 1;
                    else begin
                        mWaking[g] = 1;
                        mLeft[g]   = WAKE_CYC;
                    end
                end
            end else if (mReady[g] || mWaking[g]) begin
                if (!req[g]) begin
                    mReady[g]  = 0;
                    mWaking[g] = 0;
                    if (HOLD_CYC == 0) mRunning[g] = 0;
                    else mLeft[g] = HOLD_CYC;
                end else if (mWaking[g]) begin
                    mLeft[g] = mLeft[g] - 1;
                    if (mLeft[g] == 0) begin
                        mWaking[g] = 0;
                        mReady[g]  = 1;
                    end
                end
            end else begin
                if (req[g]) mReady[g] = 1;
                else begin
                    mLeft[g] = mLeft[g] - 1;
                    if (mLeft[g] == 0) mRunning[g] = 0;
                end
            end
        end
    endtask

    task automatic compareAll();
        logic [NGRP-1:0]       eg;
        logic [NGRP-1:0]       ea;
        logic [NGRP*CNT_W-1:0] ec;
        ec = '0;
        for (int g = 0; g < NGRP; g++) begin
            eg[g] = expGate[g] | force_on;
            ea[g] = expAck[g];
`ifdef CG_STATS_EN
            ec[g*CNT_W +: CNT_W] = CNT_W'(mCnt[g]);
`endif
        end
        checkOutput("model_gate_en", 32'(gate_en), 32'(eg));
        checkOutput("model_ack", 32'(ack), 32'(ea));
        checkOutput("model_gated_cnt", 32'(gated_cnt), 32'(ec));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) modelEdge();
        #1;
        compareAll();
    endtask

    task automatic asyncResetPulse();
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_async_gate", 32'(gate_en), 32'({NGRP{force_on}}));
        checkOutput("rst_async_ack", 32'(ack), 32'h0);
        compareAll();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NGRP*CNT_W-1:0] satExp;
        logic [NGRP-1:0]       rndReq;
        satExp = '1;

        rst_n = 1'b0;
        applyStimulus('0, 1'b0, 1'b0);
        modelReset();
        #2;
        checkOutput("reset_gate", 32'(gate_en), 32'h0);
        checkOutput("reset_ack", 32'(ack), 32'h0);
        checkOutput("reset_cnt", 32'(gated_cnt), 32'h0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("idle_gate", 32'(gate_en), 32'h0);
`ifdef CG_STATS_EN
        checkOutput("idle_cnt0", 32'(gated_cnt[CNT_W-1:0]), 32'd10);
`endif

        applyStimulus(2'b01, 1'b0, 1'b0);
        tick();
        checkOutput("wake_gate_t", 32'(gate_en), 32'h0);
        tick();
        checkOutput("wake_gate_t1", 32'(gate_en), 32'h1);
        checkOutput("wake_ack_t1", 32'(ack), 32'h0);
        tick();
        checkOutput("wake_ack_t2", 32'(ack), 32'h1);
        checkOutput("wake_grp1", 32'(gate_en[1]), 32'h0);
        repeat (3) tick();

        applyStimulus(2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("hold_ack_t", 32'(ack), 32'h1);
        tick();
        checkOutput("hold_ack_t1", 32'(ack), 32'h0);
        checkOutput("hold_gate_t1", 32'(gate_en), 32'h1);
        repeat (3) begin
            tick();
            checkOutput("hold_gate_win", 32'(gate_en), 32'h1);
        end
        tick();
        checkOutput("hold_gate_off", 32'(gate_en), 32'h0);

        applyStimulus(2'b01, 1'b0, 1'b0);
        repeat (4) tick();
        applyStimulus(2'b00, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rereq_ack_drop", 32'(ack), 32'h0);
        applyStimulus(2'b01, 1'b0, 1'b0);
        tick();
        checkOutput("rereq_gate_t", 32'(gate_en), 32'h1);
        tick();
        checkOutput("rereq_ack_back", 32'(ack), 32'h1);
        checkOutput("rereq_gate_t1", 32'(gate_en), 32'h1);

        applyStimulus(2'b00, 1'b0, 1'b0);
        repeat (7) tick();
        applyStimulus(2'b00, 1'b1, 1'b0);
        #1;
        checkOutput("force_gate", 32'(gate_en), 32'h3);
        checkOutput("force_ack", 32'(ack), 32'h0);
        tick();
        applyStimulus(2'b00, 1'b0, 1'b0);
        tick();

        applyStimulus(2'b01, 1'b0, 1'b0);
        repeat (4) tick();
        checkOutput("on_before_rst", 32'(ack), 32'h1);
        asyncResetPulse();
        applyStimulus(2'b00, 1'b0, 1'b0);
        tick();

        repeat (20) tick();
`ifdef CG_STATS_EN
        checkOutput("stats_sat", 32'(gated_cnt), 32'(satExp));
`else
        checkOutput("stats_off", 32'(gated_cnt), 32'h0);
`endif
        applyStimulus(2'b00, 1'b0, 1'b1);
        tick();
        checkOutput("stats_clr", 32'(gated_cnt), 32'h0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        tick();

        rndReq = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int g = 0; g < NGRP; g++) begin
                if ($urandom_range(3) == 0) rndReq[g] = ~rndReq[g];
            end
            applyStimulus(rndReq, ($urandom_range(15) == 0), ($urandom_range(15) == 0));
            if ($urandom_range(63) == 0) asyncResetPulse();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
